// File: rtl/cnt_defs.sv
// Shared constants and helpers for the timebase counters.
package cnt_defs;

    localparam int unsigned BOARD_CLK_HZ = 50000000;

    // Bit width needed to hold 0..n-1, never less than one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        for (w = 1; (w < 32) && ((32'd1 << w) < n); w++) begin
        end
        return w;
    endfunction

endpackage

// File: rtl/cnt_mod.sv
// Generic modulo-N counter with terminal-count flag; clear beats enable.
module cnt_mod
    import cnt_defs::*;
#(
    parameter  int unsigned N = 2,
    localparam int unsigned W = clog2(N)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         CLR,
    input  logic         EN,
    output logic [W-1:0] Q,
    output logic         TC
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] r_q;

    // Wrap by compare-and-clear so non-power-of-two moduli stay exact.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_q <= '0;
        end else if (CLR) begin
            r_q <= '0;
        end else if (EN) begin
            r_q <= (r_q == LAST) ? '0 : r_q + 1'b1;
        end
    end

    assign Q  = r_q;
    assign TC = (r_q == LAST);

endmodule

// File: rtl/cnt_timebase.sv
// Prescaled timebase: sub-tick, tick and wrap strobes, blink and tick count.
module cnt_timebase
    import cnt_defs::*;
#(
    parameter int unsigned CLK_HZ  = BOARD_CLK_HZ,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned SUBDIV  = 4,
    parameter int unsigned SEC_MOD = 60
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      RUN,
    input  logic                      CLR,
    output logic                      EN_SUB,
    output logic                      EN_TICK,
    output logic                      EN_WRAP,
    output logic                      BLINK,
    output logic [clog2(SEC_MOD)-1:0] SEC
);

    localparam int unsigned PRE = CLK_HZ / (TICK_HZ * SUBDIV);

    if ((CLK_HZ % (TICK_HZ * SUBDIV)) != 0 || PRE < 2 || SUBDIV < 2 ||
        (SUBDIV % 2) != 0 || SEC_MOD < 2) begin : g_bad_params
        $error("cnt_timebase: illegal CLK_HZ/TICK_HZ/SUBDIV/SEC_MOD combination");
    end

    logic [clog2(PRE)-1:0]    w_pre;
    logic [clog2(SUBDIV)-1:0] w_sub;
    logic                     w_pre_tc;
    logic                     w_sub_tc;
    logic                     w_sec_tc;
    logic                     w_en_sub;
    logic                     w_en_tick;
    logic                     w_run;
    logic                     w_unused;
    logic                     r_blink;

    // Strobes are qualified by the live inputs so pause and clear gate them at once.
    assign w_run     = RUN & ~CLR;
    assign w_en_sub  = w_run & w_pre_tc;
    assign w_en_tick = w_en_sub & w_sub_tc;

    cnt_mod #(.N(PRE)) u_pre (
        .CLK (CLK),
        .RST (RST),
        .CLR (CLR),
        .EN  (RUN),
        .Q   (w_pre),
        .TC  (w_pre_tc)
    );

    cnt_mod #(.N(SUBDIV)) u_sub (
        .CLK (CLK),
        .RST (RST),
        .CLR (CLR),
        .EN  (w_en_sub),
        .Q   (w_sub),
        .TC  (w_sub_tc)
    );

    cnt_mod #(.N(SEC_MOD)) u_sec (
        .CLK (CLK),
        .RST (RST),
        .CLR (CLR),
        .EN  (w_en_tick),
        .Q   (SEC),
        .TC  (w_sec_tc)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_blink <= 1'b0;
        end else if (CLR) begin
            r_blink <= 1'b0;
        end else if (w_en_sub) begin
            r_blink <= ~r_blink;
        end
    end

    assign w_unused = ^{w_pre, w_sub};

    assign EN_SUB  = w_en_sub;
    assign EN_TICK = w_en_tick;
    assign EN_WRAP = w_en_tick & w_sec_tc;
    assign BLINK   = r_blink;

endmodule

// File: tb/tb_cnt_timebase.sv
// Scoreboard bench for cnt_timebase: per-cycle expectations from an event-count model.
module tb_cnt_timebase;

    localparam int unsigned PRE     = 10;
    localparam int unsigned SUBDIV  = 4;
    localparam int unsigned SEC_MOD = 3;
    localparam int unsigned TICK_P  = PRE * SUBDIV;
    localparam int unsigned WRAP_P  = TICK_P * SEC_MOD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       clr = 1'b0;
    logic       en_sub;
    logic       en_tick;
    logic       en_wrap;
    logic       blink;
    logic [1:0] sec;

    cnt_timebase #(
        .CLK_HZ  (40),
        .TICK_HZ (1),
        .SUBDIV  (SUBDIV),
        .SEC_MOD (SEC_MOD)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .RUN     (run),
        .CLR     (clr),
        .EN_SUB  (en_sub),
        .EN_TICK (en_tick),
        .EN_WRAP (en_wrap),
        .BLINK   (blink),
        .SEC     (sec)
    );

    always #5 clk = ~clk;

    // Expected {EN_SUB, EN_TICK, EN_WRAP, BLINK, SEC} per cycle.
    logic [5:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    // Model state: number of running cycles since the last reset/clear, mod WRAP_P.
    int unsigned m_n = 0;

    task automatic step(input logic r, input logic c, input logic s);
        logic [5:0] e;
        logic       active;
        @(posedge clk);
        #1;
        run = r;
        clr = c;
        rst = s;
        cyc++;
        active = r && !c && !s;
        e = '0;
        if (s) begin
            m_n = 0;
        end else begin
            e[5]   = active && (((m_n + 1) % PRE) == 0);
            e[4]   = active && (((m_n + 1) % TICK_P) == 0);
            e[3]   = active && (((m_n + 1) % WRAP_P) == 0);
            e[2]   = ((m_n / PRE) % 2) == 1;
            e[1:0] = 2'((m_n / TICK_P) % SEC_MOD);
            if (c)      m_n = 0;
            else if (r) m_n = (m_n + 1) % WRAP_P;
        end
        exp_q.push_back(e);
    endtask

    task automatic run_to_pre(input int unsigned p);
        for (int i = 0; i < int'(WRAP_P) && (m_n % PRE) != p; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic run_to(input int unsigned target);
        for (int i = 0; i < int'(WRAP_P) && m_n != target; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        logic [5:0] e;
        logic [5:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {en_sub, en_tick, en_wrap, blink, sec};
            n_cmp++;
            if (a !== e) begin
                n_err++;
                $display("FAIL strobe_state cycle %0d: got sub=%b tick=%b wrap=%b blink=%b sec=%0d, want sub=%b tick=%b wrap=%b blink=%b sec=%0d",
                         cyc, a[5], a[4], a[3], a[2], a[1:0], e[5], e[4], e[3], e[2], e[1:0]);
            end
        end
    end

    initial begin
        // Reset held, then free run past the first wrap.
        repeat (3) step(1'b0, 1'b0, 1'b1);
        repeat (130) step(1'b1, 1'b0, 1'b0);

        // Pause landing exactly on the terminal prescaler count.
        run_to_pre(9);
        repeat (7) step(1'b0, 1'b0, 1'b0);
        repeat (25) step(1'b1, 1'b0, 1'b0);

        // Clear at SEC=2, sub=3, pre=5 (blink high there).
        run_to(2 * TICK_P + 3 * PRE + 5);
        step(1'b1, 1'b1, 1'b0);
        repeat (15) step(1'b1, 1'b0, 1'b0);

        // Clear coinciding with pre==9, then held clear with RUN low.
        run_to_pre(9);
        step(1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (12) step(1'b1, 1'b0, 1'b0);

        // Asynchronous reset mid-period.
        run_to_pre(6);
        repeat (2) step(1'b1, 1'b0, 1'b1);
        repeat (15) step(1'b1, 1'b0, 1'b0);

        // Random run/clear/reset mix.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 199) == 0);
        end

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL queue_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cnt_timebase.md
Name: cnt_timebase

Overview:
- Parametrised successor of the fixed 50 MHz one-second counter. It generates three strobes from a single clock: a sub-tick enable, a tick enable, and a wrap enable after SEC_MOD ticks.
- It also drives a 50% duty blink output and a readable tick count.
- Adds run/pause and synchronous clear control.
- Sits next to the board clock and feeds display-refresh, clock/timer and LED-blink logic.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1, EN_TICK rate in Hz.
- SUBDIV, 4, EN_SUB pulses per tick. Must be even and >= 2. BLINK frequency = TICK_HZ*SUBDIV/2.
- SEC_MOD, 60, tick-counter modulus. Must be >= 2.
- Derived constant, not overridable: PRE = CLK_HZ/(TICK_HZ*SUBDIV). It must divide exactly and be >= 2. Violations are a compile-time error (generate-block $error).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- RUN  in  1  1 = count, 0 = hold all state
- CLR  in  1  synchronous clear of all state; has priority over RUN
- EN_SUB  out  1  one-cycle strobe at TICK_HZ*SUBDIV
- EN_TICK  out  1  one-cycle strobe at TICK_HZ
- EN_WRAP  out  1  one-cycle strobe once every SEC_MOD ticks
- BLINK  out  1  square wave at TICK_HZ*SUBDIV/2, 50% duty
- SEC  out  clog2(SEC_MOD)  current tick count, 0..SEC_MOD-1

Behaviour:
- Reset (async, while RST=1): prescaler, sub counter, SEC and BLINK are all 0. EN_SUB, EN_TICK and EN_WRAP are 0.
- Prescaler pre, width clog2(PRE):
  - When RUN=1 and CLR=0: counts 0..PRE-1, then wraps to 0.
  - EN_SUB = RUN & ~CLR & (pre==PRE-1). Combinational from registers, no extra latency.
- Sub counter sub, width clog2(SUBDIV): advances only when EN_SUB=1, counting 0..SUBDIV-1 and wrapping to 0.
- EN_TICK = EN_SUB & (sub==SUBDIV-1).
- SEC: advances only when EN_TICK=1, counting 0..SEC_MOD-1 and wrapping to 0.
- EN_WRAP = EN_TICK & (SEC==SEC_MOD-1).
- BLINK: registered; toggles on every EN_SUB. Starts low after reset or clear. Each level lasts exactly PRE cycles while running.
- Strobe coincidence: EN_WRAP implies EN_TICK, and EN_TICK implies EN_SUB, in the same cycle. All three wrap in that one cycle.
- First strobes after reset release with RUN=1 (cycles counted from the first active edge as 1):
  - EN_SUB high during cycle PRE.
  - EN_TICK high during cycle PRE*SUBDIV.
  - EN_WRAP high during cycle PRE*SUBDIV*SEC_MOD.
- RUN=0:
  - All registers hold and all strobes are 0.
  - Resuming continues from the held values with no lost or duplicated strobe.
  - If RUN falls in the cycle where pre==PRE-1, the strobe is suppressed and fires in the first cycle RUN is high again.
- CLR=1:
  - At the next edge, pre, sub, SEC and BLINK go to 0.
  - Strobes are 0 during the CLR cycle, regardless of RUN.
  - CLR held for multiple cycles keeps everything at 0.
- Reset mid-count: immediate asynchronous clear. Strobes drop in the same cycle, with no glitch-to-1 from stale state.
- Arithmetic: all counters are unsigned. Each wraps by compare-and-clear at terminal count, never by natural overflow, so non-power-of-two moduli are exact.

Decomposition:
- Shared constants file (cnt_defs): a clog2 function and default CLK_HZ for the board. No typedefs.
- One sub-module, cnt_mod:
  - Generic modulo-N counter with ports CLK, RST, CLR, EN, Q, TC, where TC = (Q==N-1).
  - Instantiated three times (prescaler, sub, SEC).
  - Strobes are formed as EN & TC in cnt_timebase.

Test Plan (bench parameters: CLK_HZ=40, TICK_HZ=1, SUBDIV=4, SEC_MOD=3, so PRE=10):
- Release RST, RUN=1 for 130 cycles -> EN_SUB at cycles 10,20,...,130; EN_TICK at 40,80,120; EN_WRAP only at 120; SEC sequence 0→1 (after cycle 40), 2 (after 80), 0 (after 120).
- Same run, watch BLINK -> low for cycles 1-10, high 11-20, low 21-30 (period 20 cycles, 2 Hz-equivalent, 50% duty).
- RUN=0 for 7 cycles starting at pre==9 -> no strobe while paused; EN_SUB exactly in the first cycle after RUN returns to 1; subsequent spacing stays 10 cycles.
- CLR=1 for one cycle at SEC=2, sub=3, pre=5 with BLINK=1 -> all counters and BLINK 0 next cycle; next EN_SUB 10 cycles after CLR release; CLR concurrent with pre==9 gives no strobe.
- Assert RST asynchronously mid-period at pre=6 -> all outputs 0 before the next CLK edge; first EN_SUB 10 cycles after release.
- Default parameters, run 50,000,000 cycles -> exactly one EN_TICK, at cycle 50,000,000; BLINK toggles exactly 4 times, i.e. a 2 Hz square wave.
